// File: rtl/alu_exec_ctrl_if.sv
// Command and result handshake bundle for the ALU issue/writeback stage.
// The master drives commands and accepts results; the slave is the controller.
interface alu_exec_ctrl_if #(
  parameter int NREG = 4
);
  localparam int AW = $clog2(NREG);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [2:0]    cmd_n;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic          cmd_imm_en;
  logic [7:0]    cmd_imm;
  logic [AW-1:0] cmd_rd;
  logic          cmd_wb;

  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [5:0]    res_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_n, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm, cmd_rd, cmd_wb,
    input  cmd_ready,
    input  res_valid, res_data, res_flags,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_n, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm, cmd_rd, cmd_wb,
    output cmd_ready,
    output res_valid, res_data, res_flags,
    input  res_ready
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback stage around an external 8-bit combinational ALU: reads
// operands from a small register file, registers ALU inputs, captures result.
module alu_exec_ctrl #(
  parameter int NREG = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_exec_ctrl_if.slave            bus,
  output logic [7:0]                alu_a_o,
  output logic [7:0]                alu_b_o,
  output logic [2:0]                alu_s_o,
  output logic [2:0]                alu_n_o,
  output logic                      alu_si_o,
  input  logic [7:0]                alu_w_i,
  input  logic                      alu_co_i,
  input  logic                      alu_ov_i,
  input  logic                      alu_zero_i,
  input  logic                      alu_neg_i,
  input  logic                      alu_gt_i,
  input  logic                      alu_eq_i,
  output logic [5:0]                flags_o,
  input  logic [$clog2(NREG)-1:0]   dbg_addr_i,
  output logic [7:0]                dbg_data_o
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          cmd_ready, res_valid, accept;
  logic [7:0]    rf_q [NREG];
  logic [7:0]    alu_a_q, alu_b_q;
  logic [2:0]    alu_s_q, alu_n_q;
  logic [AW-1:0] rd_q;
  logic          wb_q;
  logic [7:0]    res_data_q;
  logic [5:0]    res_flags_q, flags_q;
  logic [7:0]    opb;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        res_valid = 1'b1;
        // A new command may ride on the same cycle the result drains.
        cmd_ready = bus.res_ready;
        if (bus.res_ready) state_d = bus.cmd_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.cmd_valid && cmd_ready;
  assign opb    = bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_rb];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_n_q     <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      flags_q     <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q <= rf_q[bus.cmd_ra];
        alu_b_q <= opb;
        alu_s_q <= bus.cmd_op;
        alu_n_q <= bus.cmd_n;
        rd_q    <= bus.cmd_rd;
        wb_q    <= bus.cmd_wb;
      end
      // Writeback lands here so the next accept always sees the new value.
      if (state_q == EXEC) begin
        res_data_q  <= alu_w_i;
        res_flags_q <= {alu_co_i, alu_ov_i, alu_zero_i, alu_neg_i, alu_gt_i, alu_eq_i};
        flags_q     <= {alu_co_i, alu_ov_i, alu_zero_i, alu_neg_i, alu_gt_i, alu_eq_i};
        if (wb_q) rf_q[rd_q] <= alu_w_i;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_s_o    = alu_s_q;
  assign alu_n_o    = alu_n_q;
  assign alu_si_o   = 1'b0;
  assign flags_o    = flags_q;
  assign dbg_data_o = rf_q[dbg_addr_i];
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed + randomized bench: a behavioural ALU feeds the DUT, and a register
// file model with the same ALU function predicts every operand and result.
module tb_alu_exec_ctrl;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    alu_a, alu_b, alu_w;
  logic [2:0]    alu_s, alu_n;
  logic          alu_si;
  logic          alu_co, alu_ov, alu_zero, alu_neg, alu_gt, alu_eq;
  logic [5:0]    flags;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  alu_exec_ctrl_if #(.NREG(NREG)) bus ();

  alu_exec_ctrl #(.NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_s_o(alu_s), .alu_n_o(alu_n), .alu_si_o(alu_si),
    .alu_w_i(alu_w), .alu_co_i(alu_co), .alu_ov_i(alu_ov), .alu_zero_i(alu_zero),
    .alu_neg_i(alu_neg), .alu_gt_i(alu_gt), .alu_eq_i(alu_eq),
    .flags_o(flags), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  // Returns {w, co, ov, zero, neg, gt, eq}.
  function automatic logic [13:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s, input logic [2:0] n);
    logic [8:0] t;
    logic [7:0] w;
    logic co, ov;
    t = '0; co = 1'b0; ov = 1'b0;
    case (s)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; w = t[7:0]; co = t[8]; ov = (a[7] == b[7]) && (w[7] != a[7]); end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; w = t[7:0]; co = t[8]; ov = (a[7] != b[7]) && (w[7] != a[7]); end
      3'd2: w = a & b;
      3'd3: w = a | b;
      3'd4: w = a ^ b;
      3'd5: w = a << n;
      3'd6: w = a >> n;
      default: w = b;
    endcase
    return {w, co, ov, (w == 8'h00), w[7], (a > b), (a == b)};
  endfunction

  always_comb {alu_w, alu_co, alu_ov, alu_zero, alu_neg, alu_gt, alu_eq} = alu_fn(alu_a, alu_b, alu_s, alu_n);

  int          passed = 0;
  int          total  = 0;
  logic [7:0]  mrf [NREG];
  logic [7:0]  exp_w;
  logic [5:0]  exp_f;
  logic [AW-1:0] fl_rd;
  logic        fl_wb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [2:0] n, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic ie, input logic [7:0] imm,
                         input logic [AW-1:0] rd, input logic wb);
    bus.cmd_op = op; bus.cmd_n = n; bus.cmd_ra = ra; bus.cmd_rb = rb;
    bus.cmd_imm_en = ie; bus.cmd_imm = imm; bus.cmd_rd = rd; bus.cmd_wb = wb;
    bus.cmd_valid = 1'b1;
  endtask

  // Called just after the accepting edge; the DUT is in its execute cycle.
  task automatic chk_issue();
    logic [7:0] ea, eb;
    ea = mrf[bus.cmd_ra];
    eb = bus.cmd_imm_en ? bus.cmd_imm : mrf[bus.cmd_rb];
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_s", alu_s, bus.cmd_op);
    chk("alu_n", alu_n, bus.cmd_n);
    chk("alu_si", alu_si, 0);
    chk("exec_res_valid", bus.res_valid, 0);
    chk("exec_cmd_ready", bus.cmd_ready, 0);
    {exp_w, exp_f} = alu_fn(ea, eb, bus.cmd_op, bus.cmd_n);
    fl_rd = bus.cmd_rd;
    fl_wb = bus.cmd_wb;
  endtask

  // Called just after the execute edge; the DUT presents its result.
  task automatic chk_result();
    chk("res_valid", bus.res_valid, 1);
    chk("res_data", bus.res_data, exp_w);
    chk("res_flags", bus.res_flags, exp_f);
    chk("flags", flags, exp_f);
    if (fl_wb) mrf[fl_rd] = exp_w;
    dbg_addr = fl_rd;
    #1;
    chk("dbg_rd", dbg_data, mrf[fl_rd]);
  endtask

  task automatic chk_rf();
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), dbg_data, mrf[i]);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] n, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic ie, input logic [7:0] imm,
                         input logic [AW-1:0] rd, input logic wb);
    set_cmd(op, n, ra, rb, ie, imm, rd, wb);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    tick(); chk_issue();
    bus.cmd_valid = 1'b0;
    tick(); chk_result();
    bus.res_ready = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] r2v;
    int stall;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
    bus.cmd_op = '0; bus.cmd_n = '0; bus.cmd_ra = '0; bus.cmd_rb = '0;
    bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0; bus.cmd_rd = '0; bus.cmd_wb = 1'b0;
    dbg_addr = '0;
    for (int i = 0; i < NREG; i++) mrf[i] = 8'h00;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_flags", flags, 0);
    chk_rf();

    // Case 1 then case 2: result stalls while the next command waits
    set_cmd(3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 8'h05, 2'd1, 1'b1);
    tick(); chk_issue();
    chk("c1_alu_b", alu_b, 8'h05);
    set_cmd(3'd1, 3'd0, 2'd1, 2'd0, 1'b1, 8'h02, 2'd2, 1'b1);
    bus.res_ready = 1'b0;
    tick(); chk_result();
    chk("c1_res_data", bus.res_data, 8'h05);
    chk("c1_res_flags", bus.res_flags, 6'b000000);
    chk("c1_dbg_r1", dbg_data, 8'h05);
    for (int k = 0; k < 5; k++) begin
      chk("stall_res_valid", bus.res_valid, 1);
      chk("stall_res_data", bus.res_data, 8'h05);
      chk("stall_cmd_ready", bus.cmd_ready, 0);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("release_cmd_ready", bus.cmd_ready, 1);
    tick(); chk_issue();
    bus.cmd_valid = 1'b0;
    tick(); chk_result();
    tick();

    // Case 3: four back-to-back commands, one accept every two cycles
    set_cmd(3'd7, 3'd0, 2'd0, 2'd0, 1'b1, 8'h33, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_issue();
      if (i == 1) chk("b2b_ra1_fwd", alu_a, 8'h33);
      if (i == 0) set_cmd(3'd0, 3'd0, 2'd1, 2'd0, 1'b1, 8'($urandom_range(0, 255)), 2'd3, 1'b1);
      else if (i < 3) set_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                              AW'($urandom_range(1, 3)), 1'b1);
      else bus.cmd_valid = 1'b0;
      tick(); chk_result();
      chk("b2b_cmd_ready", bus.cmd_ready, 1);
    end
    tick();

    // Case 4: no writeback, negative result
    run_cmd(3'd7, 3'd0, 2'd0, 2'd0, 1'b1, 8'hFF, 2'd0, 1'b0);
    chk("c4_flags", flags, 6'b000100);
    chk_rf();

    // Case 5: reset during execute drops the writeback
    set_cmd(3'd7, 3'd0, 2'd0, 2'd0, 1'b1, 8'hAA, 2'd3, 1'b1);
    tick(); chk_issue();
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) mrf[i] = 8'h00;
    chk("c5_cmd_ready", bus.cmd_ready, 1);
    chk("c5_res_valid", bus.res_valid, 0);
    chk("c5_res_data", bus.res_data, 0);
    chk("c5_res_flags", bus.res_flags, 0);
    chk("c5_flags", flags, 0);
    chk("c5_alu_a", alu_a, 0);
    chk("c5_alu_b", alu_b, 0);
    chk_rf();

    // Case 6: destination equals source
    run_cmd(3'd7, 3'd0, 2'd0, 2'd0, 1'b1, 8'h10, 2'd2, 1'b1);
    set_cmd(3'd0, 3'd0, 2'd2, 2'd0, 1'b1, 8'h01, 2'd2, 1'b1);
    tick(); chk_issue();
    chk("c6_alu_a", alu_a, 8'h10);
    bus.cmd_valid = 1'b0;
    tick(); chk_result();
    r2v = dbg_data;
    chk("c6_r2", r2v, 8'h11);
    tick();

    // Random traffic with random result stalls
    for (int k = 0; k < 30; k++) begin
      set_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int w = 0; w < 8 && bus.cmd_ready !== 1'b1; w++) tick();
      chk("rnd_accept", bus.cmd_ready, 1);
      tick(); chk_issue();
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
      tick(); chk_result();
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("rnd_hold", bus.res_data, exp_w);
      end
      bus.res_ready = 1'b1;
      tick();
    end
    chk_rf();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
